// File: rtl/jacobi_pkg.sv
// Shared constants for the Jacobi result-capture slice: data width, FSM states,
// host register map and STATUS bit positions.
package jacobi_pkg;

  localparam int DW = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

  localparam logic [7:0] ADDR_STATUS    = 8'h00;
  localparam logic [7:0] ADDR_COUNT     = 8'h01;
  localparam logic [7:0] ADDR_CTRL      = 8'h02;
  localparam logic [7:0] ADDR_DATA_BASE = 8'h08;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_FAIL = 2;
  localparam int ST_OVF  = 3;

endpackage

// File: rtl/jacobi_result_ram.sv
// Result buffer: one write port, one registered read port. A read and a write
// to the same entry on one edge returns the previous contents.
module jacobi_result_ram #(
  parameter int DW    = 27,
  parameter int DEPTH = 200,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/jacobi_result_capture.sv
// Captures the jacobi_iter result burst into a buffer and serves status/results
// over an Avalon-MM slave. Optional IRQ output: define JACOBI_CAPTURE_IRQ_EN.
module jacobi_result_capture #(
  parameter int DW    = jacobi_pkg::DW,
  parameter int DEPTH = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           N,
  input  logic                 drdy,
  input  logic signed [DW-1:0] dout,
  input  logic                 fail,
  input  logic [7:0]           avs_address,
  input  logic                 avs_read,
  output logic [31:0]          avs_readdata,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata
`ifdef JACOBI_CAPTURE_IRQ_EN
  , output logic               irq
`endif
);
  import jacobi_pkg::*;

  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH8 = 8'(DEPTH);

  cap_state_e state, state_nx;
  logic [7:0] n_lat, idx, count;
  logic       st_busy, st_done, st_fail, st_ovf;
  logic       clear, start, we;

  assign clear = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[0];

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    we       = 1'b0;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (drdy) begin
          start    = 1'b1;
          we       = !fail && (N != 8'd0);
          state_nx = (fail || N <= 8'd1) ? DONE : CAPTURE;
        end
        CAPTURE: begin
          // Indices past the buffer still advance so COUNT/OVF track the full burst.
          we = idx < DEPTH8;
          if (idx == n_lat - 8'd1) state_nx = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n_lat   <= 8'd0;
      idx     <= 8'd0;
      count   <= 8'd0;
      st_busy <= 1'b0;
      st_done <= 1'b0;
      st_fail <= 1'b0;
      st_ovf  <= 1'b0;
    end else begin
      state <= state_nx;
      if (clear) begin
        idx     <= 8'd0;
        count   <= 8'd0;
        st_busy <= 1'b0;
        st_done <= 1'b0;
        st_fail <= 1'b0;
        st_ovf  <= 1'b0;
      end else if (start) begin
        n_lat <= N;
        idx   <= 8'd1;
        if (fail) begin
          st_fail <= 1'b1;
          st_done <= 1'b1;
        end else if (N == 8'd0) begin
          st_done <= 1'b1;
        end else begin
          count   <= 8'd1;
          st_busy <= (N != 8'd1);
          st_done <= (N == 8'd1);
        end
      end else if (state == CAPTURE) begin
        idx <= idx + 8'd1;
        if (we) count  <= count + 8'd1;
        else    st_ovf <= 1'b1;
        if (state_nx == DONE) begin
          st_busy <= 1'b0;
          st_done <= 1'b1;
        end
      end
    end
  end

  // Host read path: register words are latched here, buffer words come from
  // the RAM's own output register; sel_data picks which one is presented.
  logic [7:0]    daddr;
  logic          is_data, sel_data;
  logic [31:0]   reg_word, reg_rdata;
  logic [DW-1:0] ram_rdata;

  assign daddr   = avs_address - ADDR_DATA_BASE;
  assign is_data = (avs_address >= ADDR_DATA_BASE) && (daddr < DEPTH8);

  always_comb begin
    reg_word = 32'd0;
    case (avs_address)
      ADDR_STATUS: begin
        reg_word[ST_BUSY] = st_busy;
        reg_word[ST_DONE] = st_done;
        reg_word[ST_FAIL] = st_fail;
        reg_word[ST_OVF]  = st_ovf;
      end
      ADDR_COUNT: reg_word[7:0] = count;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_data  <= 1'b0;
      reg_rdata <= 32'd0;
    end else if (avs_read) begin
      sel_data  <= is_data;
      reg_rdata <= reg_word;
    end
  end

  jacobi_result_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (idx[AW-1:0]),
    .wdata (dout),
    .re    (avs_read && is_data),
    .raddr (daddr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign avs_readdata = sel_data ? {{(32-DW){ram_rdata[DW-1]}}, ram_rdata} : reg_rdata;

  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:1];

`ifdef JACOBI_CAPTURE_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (avs_write && avs_address == ADDR_CTRL) irq_en <= avs_writedata[1];
      if (clear)                                 irq    <= 1'b0;
      else if (irq_en && (st_done || st_fail))   irq    <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jacobi_result_capture.sv
// Bench: two instances (DEPTH 200 and 4) share stimulus; vector table, hand
// sequences and random bursts are checked against a buffer/status model.
module tb_jacobi_result_capture;
  localparam int DW = 27;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] N;
  logic drdy, fail;
  logic signed [DW-1:0] dout;
  logic [7:0] avs_address;
  logic avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] rd_a, rd_b;
`ifdef JACOBI_CAPTURE_IRQ_EN
  logic irq_a, irq_b;
`endif

  always #5 clk = ~clk;

  jacobi_result_capture #(.DW(DW), .DEPTH(200)) dut_a (
    .clk(clk), .rst(rst), .N(N), .drdy(drdy), .dout(dout), .fail(fail),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(rd_a),
    .avs_write(avs_write), .avs_writedata(avs_writedata)
`ifdef JACOBI_CAPTURE_IRQ_EN
    , .irq(irq_a)
`endif
  );

  jacobi_result_capture #(.DW(DW), .DEPTH(DB)) dut_b (
    .clk(clk), .rst(rst), .N(N), .drdy(drdy), .dout(dout), .fail(fail),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(rd_b),
    .avs_write(avs_write), .avs_writedata(avs_writedata)
`ifdef JACOBI_CAPTURE_IRQ_EN
    , .irq(irq_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected buffer contents plus whether the block is armed.
  logic [31:0] mem [256];
  bit          valid [256];
  bit          armed;
  int          bv [16];

  typedef struct {
    int          n;
    bit          f;
    int          clr_at;
    int          vi;
    logic [31:0] st_a, cnt_a, st_b, cnt_b;
  } vec_t;

  vec_t vec [8];
  int   vt [8][8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int v);
    logic [DW-1:0] t;
    t = v[DW-1:0];
    return {{(32-DW){t[DW-1]}}, t};
  endfunction

  task automatic rd(input logic [7:0] a, output logic [31:0] va, output logic [31:0] vb);
    @(negedge clk);
    avs_read = 1'b1; avs_address = a;
    @(negedge clk);
    avs_read = 1'b0;
    va = rd_a; vb = rd_b;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge clk);
    avs_write = 1'b0;
    if (a == 8'h02 && d[0]) armed = 1'b1;
  endtask

  // drdy pulses with element 0; clr_at >= 0 writes CTRL clear alongside that element.
  task automatic burst(input int n, input bit f, input int clr_at);
    int len;
    len = (n < 1) ? 1 : n;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      drdy = (i == 0);
      fail = (i == 0) ? f : 1'b0;
      N    = 8'(n);
      dout = bv[i][DW-1:0];
      avs_write = (i == clr_at); avs_address = 8'h02; avs_writedata = 32'd1;
    end
    @(negedge clk);
    drdy = 1'b0; fail = 1'b0; avs_write = 1'b0;
    if (armed && !f)
      for (int i = 0; i < n; i++)
        if (clr_at < 0 || i < clr_at) begin
          mem[i] = sx(bv[i]); valid[i] = 1'b1;
        end
    armed = (clr_at >= 0);
  endtask

  task automatic check_regs(input string tag, input logic [31:0] sa, input logic [31:0] ca,
                            input logic [31:0] sb, input logic [31:0] cb);
    logic [31:0] va, vb;
    rd(8'h00, va, vb);
    check({tag, " status_a"}, va, sa);
    check({tag, " status_b"}, vb, sb);
    rd(8'h01, va, vb);
    check({tag, " count_a"}, va, ca);
    check({tag, " count_b"}, vb, cb);
  endtask

  task automatic check_data(input string tag, input int upto);
    logic [31:0] va, vb;
    for (int i = 0; i < upto; i++) begin
      rd(8'(8 + i), va, vb);
      if (valid[i]) check($sformatf("%s data_a[%0d]", tag, i), va, mem[i]);
      if (i >= DB) check($sformatf("%s data_b[%0d]", tag, i), vb, 32'd0);
      else if (valid[i]) check($sformatf("%s data_b[%0d]", tag, i), vb, mem[i]);
    end
  endtask

  initial begin
    logic [31:0] va, vb, old0, exp_st, exp_cnt_a, exp_cnt_b, exp_st_b;
    int n, c;
    bit f;

    rst = 1'b1; N = 8'd0; drdy = 1'b0; dout = '0; fail = 1'b0;
    avs_address = 8'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
    armed = 1'b1;
    for (int i = 0; i < 256; i++) begin mem[i] = 32'd0; valid[i] = 1'b0; end

    vt = '{'{5, -7, 12, 0, 0, 0, 0, 0}, '{1, 2, 3, 4, 0, 0, 0, 0},
           '{1, 2, 3, 4, 5, 6, 0, 0},   '{21, 22, 23, 24, 25, 0, 0, 0},
           '{9, 8, 0, 0, 0, 0, 0, 0},   '{0, 0, 0, 0, 0, 0, 0, 0},
           '{-1, 0, 0, 0, 0, 0, 0, 0},  '{40, 41, 42, 0, 0, 0, 0, 0}};
    vec[0] = '{3, 1'b0, -1, 0, 32'h2, 32'd3, 32'h2, 32'd3};
    vec[1] = '{4, 1'b1, -1, 1, 32'h6, 32'd0, 32'h6, 32'd0};
    vec[2] = '{6, 1'b0, -1, 2, 32'h2, 32'd6, 32'hA, 32'd4};
    vec[3] = '{5, 1'b0,  2, 3, 32'h0, 32'd0, 32'h0, 32'd0};
    vec[4] = '{2, 1'b0, -1, 4, 32'h2, 32'd2, 32'h2, 32'd2};
    vec[5] = '{0, 1'b0, -1, 5, 32'h2, 32'd0, 32'h2, 32'd0};
    vec[6] = '{1, 1'b0, -1, 6, 32'h2, 32'd1, 32'h2, 32'd1};
    vec[7] = '{3, 1'b0,  0, 7, 32'h0, 32'd0, 32'h0, 32'd0};

    repeat (2) @(negedge clk);
    check("reset readdata_a", rd_a, 32'd0);
    check("reset readdata_b", rd_b, 32'd0);
    rst = 1'b0;
    check_regs("reset", 32'd0, 32'd0, 32'd0, 32'd0);

    for (int k = 0; k < 8; k++) begin
      wr(8'h02, 32'd1);
      for (int i = 0; i < 8; i++) bv[i] = vt[vec[k].vi][i];
      burst(vec[k].n, vec[k].f, vec[k].clr_at);
      check_regs($sformatf("vec%0d", k), vec[k].st_a, vec[k].cnt_a, vec[k].st_b, vec[k].cnt_b);
      check_data($sformatf("vec%0d", k), vec[k].n + 1);
      if (vec[k].st_a[1]) begin
        for (int i = 0; i < 8; i++) bv[i] = 1000 + i;
        burst(vec[k].n + 1, 1'b0, -1);
        check_regs($sformatf("vec%0d rearm", k), vec[k].st_a, vec[k].cnt_a, vec[k].st_b, vec[k].cnt_b);
        check_data($sformatf("vec%0d rearm", k), vec[k].n + 1);
      end
    end

    // Host read of DATA[0] on the same edge element 0 is written returns the old word.
    wr(8'h02, 32'd1);
    old0 = mem[0];
    @(negedge clk);
    drdy = 1'b1; N = 8'd2; dout = 27'sd100; avs_read = 1'b1; avs_address = 8'h08;
    @(negedge clk);
    drdy = 1'b0; dout = 27'sd101; avs_read = 1'b0;
    check("rd_during_wr_a", rd_a, old0);
    check("rd_during_wr_b", rd_b, old0);
    @(negedge clk);
    mem[0] = 32'd100; mem[1] = 32'd101; valid[0] = 1'b1; valid[1] = 1'b1; armed = 1'b0;
    check_regs("rdwr", 32'h2, 32'd2, 32'h2, 32'd2);
    check_data("rdwr", 2);
    repeat (2) @(negedge clk);
    check("read_hold_a", rd_a, mem[1]);

    // Reset in the middle of an N=5 burst.
    wr(8'h02, 32'd1);
    @(negedge clk); drdy = 1'b1; N = 8'd5; dout = 27'sd1;
    @(negedge clk); drdy = 1'b0; dout = 27'sd2;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 256; i++) valid[i] = 1'b0;
    armed = 1'b1;
    check("midrst readdata_a", rd_a, 32'd0);
    check("midrst readdata_b", rd_b, 32'd0);
    check_regs("midrst", 32'd0, 32'd0, 32'd0, 32'd0);
    rd(8'h05, va, vb);
    check("unmapped05_a", va, 32'd0);
    check("unmapped05_b", vb, 32'd0);

`ifdef JACOBI_CAPTURE_IRQ_EN
    wr(8'h02, 32'd3);
    bv[0] = 7; bv[1] = 8;
    burst(2, 1'b0, -1);
    @(negedge clk);
    check("irq_set_a", {31'd0, irq_a}, 32'd1);
    wr(8'h02, 32'd1);
    check("irq_clr_a", {31'd0, irq_a}, 32'd0);
`endif

    for (int r = 0; r < 20; r++) begin
      wr(8'h02, 32'd1);
      n = $urandom_range(0, 12);
      f = ($urandom_range(0, 7) == 0);
      c = (n > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      for (int i = 0; i < 16; i++) bv[i] = int'($urandom);
      burst(n, f, c);
      if (c >= 0) begin
        exp_st = 0; exp_st_b = 0; exp_cnt_a = 0; exp_cnt_b = 0;
      end else if (f) begin
        exp_st = 32'h6; exp_st_b = 32'h6; exp_cnt_a = 0; exp_cnt_b = 0;
      end else begin
        exp_st    = 32'h2;
        exp_st_b  = (n > DB) ? 32'hA : 32'h2;
        exp_cnt_a = 32'(n);
        exp_cnt_b = 32'((n > DB) ? DB : n);
      end
      check_regs($sformatf("rnd%0d", r), exp_st, exp_cnt_a, exp_st_b, exp_cnt_b);
      check_data($sformatf("rnd%0d", r), n + 1);
      rd(8'($urandom_range(3, 7)), va, vb);
      check($sformatf("rnd%0d unmapped_a", r), va, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jacobi_result_capture.md
# jacobi_result_capture

Downstream stage of `jacobi_iter`. It watches `drdy`, `dout` and `fail`, captures the N-element solution vector burst into an internal buffer, and records completion and fail status. It then serves status and results to the host over a simple Avalon-MM read/write slave. This decouples the host from the one-shot, cycle-exact result burst of the solver.

## Interface
Parameters:
- `DW`, 27: solver data width (signed).
- `DEPTH`, 200: result buffer entries. Must not exceed 248.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `N`  in  8  vector length; same value the solver uses.
- `drdy`  in  1  solver result-ready.
- `dout`  in  DW  solver result stream, signed.
- `fail`  in  1  solver non-convergence flag; valid while `drdy` is high.
- `avs_address`  in  8  word address.
- `avs_read`  in  1  read strobe.
- `avs_readdata`  out  32  read data.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `irq`  out  1  completion interrupt. Present only with `JACOBI_CAPTURE_IRQ_EN`.

## Operation
- States:
  - IDLE (armed)
  - CAPTURE
  - DONE
- IDLE -> CAPTURE on the first edge with `drdy`=1. On that edge:
  - latch `N` into `n_lat`;
  - store `dout` as element 0;
  - set busy.
- IDLE -> DONE directly on that edge in either case:
  - `fail`=1: set FAIL, store nothing, COUNT=0;
  - `N`=0: COUNT=0.
- CAPTURE: store `dout` as element i on each following consecutive edge, for i=1..n_lat-1. `drdy` and `fail` are ignored after the first edge. After element n_lat-1: busy=0, done=1, go to DONE.
- Element index i ≥ DEPTH: the write is dropped, the OVF bit is set, and counting still runs to n_lat.
- COUNT = min(n_lat, DEPTH) once done; it holds the running count during CAPTURE.
- DONE: `drdy` is ignored. Only a CTRL clear re-arms.
- Register map (word addresses):
  - 0x00 STATUS, read-only: bit0 busy, bit1 done, bit2 fail, bit3 ovf.
  - 0x01 COUNT, read-only: bits[7:0].
  - 0x02 CTRL, write: bit0 clear. Clear returns to IDLE, zeroes STATUS and COUNT, and leaves buffer contents unchanged.
  - 0x08+i DATA[i], read-only, for i < DEPTH: `dout` sign-extended to 32 bits.
- Unmapped reads return 0. Writes to read-only addresses are ignored.
- Clear in the same cycle as `drdy` in IDLE: clear wins and the burst is not captured.
- Clear during CAPTURE: aborts immediately to IDLE.
- Simultaneous host read of DATA[i] and capture write of DATA[i]: the read returns the old value.

## Timing
- Reset values: state IDLE, STATUS 0, COUNT 0, `avs_readdata` 0, `irq` 0. Buffer contents are undefined.
- `rst` mid-capture: returns to IDLE on that edge. No partial status is kept.
- Element i is sampled on edge k+i, where k is the first edge with `drdy`=1. This is exactly the solver burst: element 0 is present in the same cycle `drdy` rises.
- Done rises on edge k+n_lat-1, visible from the next cycle.
- Read latency is 1 cycle: `avs_readdata` is registered on the edge where `avs_read`=1 and held until the next read. No wait states.
- Writes take effect on the strobe edge.

## Configuration
- `JACOBI_CAPTURE_IRQ_EN` defined:
  - adds the `irq` port and CTRL bit1 `irq_en` (reset 0);
  - `irq` is a registered level, set the cycle after done or fail becomes 1 while `irq_en`=1;
  - `irq` is cleared by the CTRL clear.
- Undefined: no `irq` port, CTRL bit1 is ignored, and there is no IRQ logic.

## Structure
- Shared package `jacobi_pkg` holds:
  - `DW` data width;
  - state enum (IDLE, CAPTURE, DONE);
  - register address constants (ADDR_STATUS, ADDR_COUNT, ADDR_CTRL, ADDR_DATA_BASE=8);
  - STATUS bit positions.
- Sub-module `jacobi_result_ram`: one write port, one registered read port, DEPTH×DW.

## Test plan
- N=3, burst `dout`=5,-7,12 from the `drdy` edge -> STATUS=0x2, COUNT=3, DATA[0..2] read 0x00000005, 0xFFFFFFF9, 0x0000000C.
- N=4, `drdy`=1 with `fail`=1 -> STATUS=0x6, COUNT=0, buffer unchanged; a second `drdy` is ignored until clear.
- DEPTH=4, N=6, burst 1..6 -> STATUS=0xA, COUNT=4, DATA[0..3]=1..4.
- Clear written at element 2 of an N=5 burst -> STATUS=0, IDLE; the next `drdy` burst of 9,8 with N=2 captures correctly.
- `rst` asserted mid-burst -> all outputs 0. A read of address 0x05 returns 0, one cycle after `avs_read`.
- With `JACOBI_CAPTURE_IRQ_EN`, irq_en=1, N=2 -> `irq` high the cycle after done; CTRL clear drops it.
